gfx_write_queue: RTL and testbench

Write buffer between the GPMC host adapter and the main graphics module, in the `pixel_clk` domain. Captures each host write the adapter presents (VRAM or register), stores it in a FIFO, and replays it to the main module's `host_*` port with a cs/done handshake, issuing only while `gfx_write_avail` is high. Writes that arrive while the main module is stalled are retained rather than dropped, up to `DEPTH` entries.

---
 rtl/gfx_write_queue.sv | 193 +++++++++++++++++++
 tb/tb_gfx_write_queue.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_write_queue.sv
// gfx_write_queue: host write buffer in the pixel_clk domain.
// Captures one entry per adapter host write (rising edge of either select),
// queues it, and replays it to the main module's host port with a cs/done
// handshake, issuing only while gfx_write_avail is high.
// Optional build macro: GFX_WRITE_QUEUE_STATS_EN enables the saturating
// dropped-write counter on q_drop_count (tied to zero otherwise).
module gfx_write_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic              pixel_clk,
   input  logic              reset,
   input  logic              up_vram_cs,
   input  logic              up_reg_cs,
   input  logic [13:1]       up_addr,
   input  logic [15:0]       up_data,
   output logic              up_ready,
   output logic              gfx_vram_cs,
   output logic              gfx_reg_cs,
   output logic [13:1]       gfx_addr,
   output logic [15:0]       gfx_data,
   input  logic              gfx_done,
   input  logic              gfx_write_avail,
   output logic [PTR_W:0]    q_count,
   output logic              q_overflow,
   output logic [7:0]        q_drop_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   typedef struct packed {
      logic        is_reg;
      logic [13:1] addr;
      logic [15:0] data;
   } entry_t;

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   state_e             state_q, state_d;
   logic               prev_sel_q, prev_sel_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               vram_cs_q, vram_cs_d;
   logic               reg_cs_q, reg_cs_d;
   logic [13:1]        addr_q, addr_d;
   logic [15:0]        data_q, data_d;
   logic               overflow_q, overflow_d;

   entry_t             mem_q [DEPTH];
   entry_t             up_entry;
   entry_t             head_entry;

   logic               sel;
   logic               push_req;
   logic               full;
   logic               push;
   logic               drop;
   logic               pop;

   // Push detection: one push per select rising edge; fullness judged before the edge.
   always_comb begin
      sel        = up_vram_cs | up_reg_cs;
      push_req   = sel & ~prev_sel_q;
      full       = (count_q == FULL_COUNT);
      push       = push_req & ~full;
      drop       = push_req & full;
      pop        = (state_q == ST_BUSY) & gfx_done;
      prev_sel_d = sel;
      // A dual select is treated as a register write.
      up_entry   = '{is_reg: up_reg_cs, addr: up_addr, data: up_data};
      head_entry = mem_q[rd_ptr_q];
   end

   // Queue bookkeeping: pointers wrap modulo DEPTH, count tracks occupancy.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | drop;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Issue FSM next state and registered host-port outputs.
   always_comb begin
      state_d   = state_q;
      vram_cs_d = vram_cs_q;
      reg_cs_d  = reg_cs_q;
      addr_d    = addr_q;
      data_d    = data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (count_q != '0 && gfx_write_avail) begin
               state_d   = ST_BUSY;
               addr_d    = head_entry.addr;
               data_d    = head_entry.data;
               reg_cs_d  = head_entry.is_reg;
               vram_cs_d = ~head_entry.is_reg;
            end
         end
         ST_BUSY: begin
            if (gfx_done) begin
               state_d   = ST_GAP;
               vram_cs_d = 1'b0;
               reg_cs_d  = 1'b0;
            end
         end
         ST_GAP: begin
            // Guarantees at least one low-cs cycle between writes.
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            vram_cs_d = 1'b0;
            reg_cs_d  = 1'b0;
         end
      endcase
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge pixel_clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state_q    <= ST_IDLE;
         prev_sel_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         vram_cs_q  <= 1'b0;
         reg_cs_q   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_sel_q <= prev_sel_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         vram_cs_q  <= vram_cs_d;
         reg_cs_q   <= reg_cs_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage, written on an accepted push.
   always_ff @(posedge pixel_clk) begin
      // NOTE: storage has no reset; an entry is only read after count says it was written.
      if (push) mem_q[wr_ptr_q] <= up_entry;
   end

`ifdef GFX_WRITE_QUEUE_STATS_EN
   logic [7:0] drop_count_q, drop_count_d;

   // Saturating count of dropped pushes.
   always_comb begin
      drop_count_d = drop_count_q;
      if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
   end

   // Drop counter register, cleared only by reset.
   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) drop_count_q <= 8'd0;
      else       drop_count_q <= drop_count_d;
   end

   assign q_drop_count = drop_count_q;
`else
   assign q_drop_count = 8'd0;
`endif

   assign up_ready    = (count_q < FULL_COUNT);
   assign gfx_vram_cs = vram_cs_q;
   assign gfx_reg_cs  = reg_cs_q;
   assign gfx_addr    = addr_q;
   assign gfx_data    = data_q;
   assign q_count     = count_q;
   assign q_overflow  = overflow_q;

endmodule

// File: tb/tb_gfx_write_queue.sv
// Self-checking bench for gfx_write_queue: directed test-plan scenarios plus
// a randomized phase, compared every cycle against a queue-based model.
module tb_gfx_write_queue;

   localparam int DEPTH = 8;
   localparam int PTR_W = 3;

   logic              pixel_clk = 1'b0;
   logic              reset;
   logic              up_vram_cs;
   logic              up_reg_cs;
   logic [13:1]       up_addr;
   logic [15:0]       up_data;
   logic              up_ready;
   logic              gfx_vram_cs;
   logic              gfx_reg_cs;
   logic [13:1]       gfx_addr;
   logic [15:0]       gfx_data;
   logic              gfx_done;
   logic              gfx_write_avail;
   logic [PTR_W:0]    q_count;
   logic              q_overflow;
   logic [7:0]        q_drop_count;

   gfx_write_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .pixel_clk       (pixel_clk),
      .reset           (reset),
      .up_vram_cs      (up_vram_cs),
      .up_reg_cs       (up_reg_cs),
      .up_addr         (up_addr),
      .up_data         (up_data),
      .up_ready        (up_ready),
      .gfx_vram_cs     (gfx_vram_cs),
      .gfx_reg_cs      (gfx_reg_cs),
      .gfx_addr        (gfx_addr),
      .gfx_data        (gfx_data),
      .gfx_done        (gfx_done),
      .gfx_write_avail (gfx_write_avail),
      .q_count         (q_count),
      .q_overflow      (q_overflow),
      .q_drop_count    (q_drop_count)
   );

   always #5 pixel_clk = ~pixel_clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: accepted writes in arrival order; the head is the one
   // on the bus while a write is in flight.
   typedef struct {
      bit        is_reg;
      bit [12:0] addr;
      bit [15:0] data;
   } wr_t;

   wr_t       m_q[$];
   bit        m_prev_sel;
   bit        m_busy;
   bit        m_gap;
   bit        m_overflow;
   bit        m_vram;
   bit        m_reg;
   bit [12:0] m_addr;
   bit [15:0] m_data;
   int        m_drops;
   int        m_collisions;

   // Stimulus knobs.
   int  done_mode;   // 0: answer done in the first cs cycle, 1: random, 2: never
   bit  rand_avail;
   int  pulses_vram;
   int  pulses_reg;
   bit  last_vram;
   bit  last_reg;

   task automatic model_reset();
      m_q.delete();
      m_prev_sel = 0;
      m_busy     = 0;
      m_gap      = 0;
      m_overflow = 0;
      m_vram     = 0;
      m_reg      = 0;
      m_addr     = '0;
      m_data     = '0;
      m_drops    = 0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int pre_size;
      bit sel;
      bit push_req;
      bit popped;
      pre_size   = m_q.size();
      sel        = up_vram_cs | up_reg_cs;
      push_req   = sel && !m_prev_sel;
      m_prev_sel = sel;
      popped     = 0;
      if (m_busy && gfx_done) begin
         void'(m_q.pop_front());
         m_busy = 0;
         m_gap  = 1;
         m_vram = 0;
         m_reg  = 0;
         popped = 1;
      end else if (m_gap) begin
         m_gap = 0;
      end else if (!m_busy && pre_size > 0 && gfx_write_avail) begin
         m_busy = 1;
         m_addr = m_q[0].addr;
         m_data = m_q[0].data;
         m_reg  = m_q[0].is_reg;
         m_vram = !m_q[0].is_reg;
      end
      if (push_req) begin
         if (pre_size == DEPTH) begin
            m_overflow = 1;
            if (m_drops < 255) m_drops++;
         end else begin
            m_q.push_back('{is_reg: up_reg_cs, addr: up_addr, data: up_data});
            if (popped) m_collisions++;
         end
      end
   endtask

   task automatic check_outputs();
      int exp_drops;
`ifdef GFX_WRITE_QUEUE_STATS_EN
      exp_drops = m_drops;
`else
      exp_drops = 0;
`endif
      check("vram_cs",    gfx_vram_cs,  m_vram);
      check("reg_cs",     gfx_reg_cs,   m_reg);
      check("addr",       gfx_addr,     m_addr);
      check("data",       gfx_data,     m_data);
      check("q_count",    q_count,      m_q.size());
      check("up_ready",   up_ready,     m_q.size() < DEPTH);
      check("overflow",   q_overflow,   m_overflow);
      check("drop_count", q_drop_count, exp_drops);
   endtask

   // One clock: drive inputs at the falling edge, update the model at the
   // rising edge, compare just after it.
   task automatic step(input bit v, input bit r, input bit [12:0] a, input bit [15:0] d);
      @(negedge pixel_clk);
      up_vram_cs = v;
      up_reg_cs  = r;
      up_addr    = a;
      up_data    = d;
      if (rand_avail) gfx_write_avail = ($urandom_range(0, 9) < 7);
      case (done_mode)
         0:       gfx_done = gfx_vram_cs | gfx_reg_cs;
         1:       gfx_done = 1'($urandom_range(0, 1));
         default: gfx_done = 1'b0;
      endcase
      @(posedge pixel_clk);
      model_edge();
      #1;
      check_outputs();
      if (gfx_vram_cs && !last_vram) pulses_vram++;
      if (gfx_reg_cs && !last_reg)   pulses_reg++;
      last_vram = gfx_vram_cs;
      last_reg  = gfx_reg_cs;
   endtask

   task automatic host_write(input bit v, input bit r, input bit [12:0] a, input bit [15:0] d,
                             input int hold, input int gap);
      repeat (hold) step(v, r, a, d);
      repeat (gap)  step(1'b0, 1'b0, a, d);
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while ((m_q.size() != 0 || m_busy || m_gap) && k < 200) begin
         step(1'b0, 1'b0, '0, '0);
         k++;
      end
      check(tag, (k < 200), 1);
      check({tag, "_empty"}, q_count, 0);
   endtask

   task automatic clear_pulses();
      pulses_vram = 0;
      pulses_reg  = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      up_vram_cs      = 1'b0;
      up_reg_cs       = 1'b0;
      up_addr         = '0;
      up_data         = '0;
      gfx_done        = 1'b0;
      gfx_write_avail = 1'b0;
      done_mode       = 0;
      rand_avail      = 0;
      last_vram       = 0;
      last_reg        = 0;
      m_collisions    = 0;
      clear_pulses();
      model_reset();

      // Reset state.
      repeat (2) @(posedge pixel_clk);
      #1;
      check("rst_vram_cs",  gfx_vram_cs,  0);
      check("rst_reg_cs",   gfx_reg_cs,   0);
      check("rst_q_count",  q_count,      0);
      check("rst_up_ready", up_ready,     1);
      check("rst_addr",     gfx_addr,     0);
      check("rst_data",     gfx_data,     0);
      check("rst_overflow", q_overflow,   0);
      check("rst_drops",    q_drop_count, 0);
      @(negedge pixel_clk);
      reset = 1'b0;

      // Single write held for six cycles.
      gfx_write_avail = 1'b1;
      done_mode       = 0;
      clear_pulses();
      host_write(1, 0, 13'h0123, 16'hBEEF, 6, 4);
      drain("single_drain");
      check("single_vram_pulses", pulses_vram, 1);
      check("single_reg_pulses",  pulses_reg,  0);

      // Stall then drain in order.
      gfx_write_avail = 1'b0;
      clear_pulses();
      host_write(0, 1, 13'h1000, 16'h0001, 2, 1);
      host_write(1, 0, 13'h0002, 16'h0002, 2, 1);
      host_write(1, 0, 13'h0003, 16'h0003, 2, 1);
      check("stall_count", q_count, 3);
      check("stall_no_cs", pulses_vram + pulses_reg, 0);
      gfx_write_avail = 1'b1;
      drain("stall_drain");
      check("stall_reg_pulses",  pulses_reg,  1);
      check("stall_vram_pulses", pulses_vram, 2);

      // Overflow: ten pushes into eight entries.
      gfx_write_avail = 1'b0;
      clear_pulses();
      for (int i = 0; i < 10; i++) host_write(1, 0, 13'(i + 16), 16'(i * 3), 1, 1);
      check("ovf_count",    q_count,    8);
      check("ovf_ready",    up_ready,   0);
      check("ovf_overflow", q_overflow, 1);
`ifdef GFX_WRITE_QUEUE_STATS_EN
      check("ovf_drops",    q_drop_count, 2);
`endif
      gfx_write_avail = 1'b1;
      drain("ovf_drain");
      check("ovf_issued", pulses_vram, 8);

      // Push/pop collisions with pointer wrap.
      clear_pulses();
      m_collisions = 0;
      host_write(1, 0, 13'h0AAA, 16'h5555, 1, 1);
      for (int i = 0; i < 20; i++) host_write(1, 0, 13'(i + 32), 16'(16'hC000 + i), 1, 2);
      drain("coll_drain");
      check("coll_issued", pulses_vram, 21);

      // Reset while a register write is in flight with four entries queued.
      gfx_write_avail = 1'b0;
      host_write(0, 1, 13'h0100, 16'h1111, 1, 1);
      host_write(1, 0, 13'h0101, 16'h2222, 1, 1);
      host_write(1, 0, 13'h0102, 16'h3333, 1, 1);
      host_write(0, 1, 13'h0103, 16'h4444, 1, 1);
      done_mode       = 2;
      gfx_write_avail = 1'b1;
      step(1'b0, 1'b0, '0, '0);
      check("busy_reg_cs", gfx_reg_cs, 1);
      @(negedge pixel_clk);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("rbusy_reg_cs",   gfx_reg_cs,  0);
      check("rbusy_vram_cs",  gfx_vram_cs, 0);
      check("rbusy_count",    q_count,     0);
      check("rbusy_ready",    up_ready,    1);
      check("rbusy_overflow", q_overflow,  0);
      @(negedge pixel_clk);
      reset     = 1'b0;
      last_vram = 0;
      last_reg  = 0;
      done_mode = 0;
      clear_pulses();
      repeat (10) step(1'b0, 1'b0, '0, '0);
      check("rbusy_no_stale", pulses_vram + pulses_reg, 0);

      // Dual select becomes a single register write.
      clear_pulses();
      host_write(1, 1, 13'h0555, 16'h1234, 3, 2);
      drain("dual_drain");
      check("dual_reg_pulses",  pulses_reg,  1);
      check("dual_vram_pulses", pulses_vram, 0);

      // Randomized traffic with random stalls and done timing.
      rand_avail = 1;
      done_mode  = 1;
      for (int i = 0; i < 60; i++) begin
         host_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    13'($urandom), 16'($urandom),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
      end
      rand_avail      = 0;
      gfx_write_avail = 1'b1;
      done_mode       = 0;
      drain("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
